alu_retire_stage: RTL and testbench
===================================

Name: alu_retire_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Each cycle it captures the ALU result together with the operands and the 6-bit opcode that produced it.
- It computes correct Z/N/C/V status flags, decides register write-back, and holds everything in a 2-entry skid buffer with a valid/ready handshake toward the write-back port.
- It owns the architectural flag register, which updates in program order at retirement.

Parameters:
- DW, 16, datapath width; the flag rules below are defined for 16.
- RW, 3, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid ALU operation.
- in_ready  output  1  stage can accept an operation this cycle.
- in_a  input  DW  ALU src1.
- in_b  input  DW  ALU src2.
- in_op  input  6  ALU control code.
- in_result  input  DW  ALU result.
- in_rd  input  RW  destination register index.
- out_valid  output  1  a retiring entry is presented.
- out_ready  input  1  write-back accepts the entry.
- out_result  output  DW  registered result.
- out_rd  output  RW  registered destination index.
- out_wb_en  output  1  write the result to the register file.
- flags_q  output  4  architectural flags {V,C,N,Z}.
- div0_pulse  output  1  one-cycle pulse when a DIV or MOD with b==0 retires.
- illegal_pulse  output  1  one-cycle pulse when an undefined opcode retires.

Behaviour:
- Reset: asynchronous, active-high.
  - in_ready=1, out_valid=0, out_result=0, out_rd=0, out_wb_en=0.
  - flags_q=0, both pulses 0, both buffer entries invalid.
  - Asserting rst mid-transfer drops all buffered entries. Nothing retires and flags are not updated.
- Acceptance and latency:
  - An entry is accepted on in_valid&&in_ready.
  - It appears at the output the next cycle, 1-cycle latency.
  - Flags are computed combinationally from in_* and stored with the entry.
- Skid buffer:
  - in_ready = !skid_valid, registered, so in_ready has no combinational path from out_ready.
  - Accepting while the output register is full and out_ready=0 sends the entry to the skid slot.
  - On an out handshake the skid entry moves to the output register.
  - Order is strictly FIFO, and simultaneous accept and retire are supported.
  - Sustained throughput is 1 entry per cycle while out_ready=1.
- Retirement (out_valid&&out_ready):
  - flags_q is loaded with the entry's flags if its op is flag-setting; otherwise flags_q holds.
  - The div0 and illegal pulses assert in the same cycle as the retirement.
- Op classes (wb = write-back, fs = flag-setting):
  - ADD 000000, SUB 000001, INC 010001, DEC 010010: wb, fs, full Z/N/C/V.
  - SHL 000010, SHR 000011, ASL 000100, ASR 000101: wb, fs; V=0.
  - MOV 000110, MUL 000111, AND 001010, OR 001011, XOR 001101, NOT 001110: wb, fs; C=0, V=0.
  - DIV 001000, MOD 001001: wb, fs; C=0; V=1 only when b==0.
  - CMP 001111, TST 010000: no wb, fs.
  - All other codes (e.g. 001100): no wb, no flag update; illegal_pulse fires.
- Flag rules:
  - Z = (result==0).
  - N = result[15].
  - ADD: C is the carry out of the 17-bit sum a+b. V = (a[15]==b[15]) && (result[15]!=a[15]).
  - SUB/CMP: C is the borrow, (a<b) unsigned. V = (a[15]!=b[15]) && (result[15]!=a[15]).
  - INC: C=(a==16'hFFFF), V=(a==16'h7FFF).
  - DEC: C=(a==0), V=(a==16'h8000).
  - SHL/ASL: C = a[16-b] for 1<=b<=16, else 0.
  - SHR/ASR: C = a[b-1] for 1<=b<=16. For b>16, SHR gives C=0 and ASR gives C=a[15]. For b==0, C=0.
- The stage never alters in_result. The stored result is exactly what the ALU produced.

Decomposition:
- Shared package alu_pkg holds:
  - the 6-bit opcode localparams (ADD..DEC);
  - flag bit indices Z=0, N=1, C=2, V=3;
  - a function op_class(op) returning {wb, fs, legal}.
- One sub-module, alu_flag_gen: purely combinational, taking a, b, op, result and producing flags and div0.
- This top module holds the skid buffer and the flag register.

Test Plan:
- ADD a=16'h7FFF b=1 result=16'h8000, out_ready=1: out_valid next cycle, out_wb_en=1; after retirement flags_q={V1,C0,N1,Z0}.
- SUB a=3 b=5 result=16'hFFFE: flags_q={V0,C1,N1,Z0}. Then CMP a=9 b=9 result=0: flags_q={V0,C0,N0,Z1}, out_wb_en=0.
- Backpressure: hold out_ready=0 and offer 3 back-to-back ops.
  - Ops 1 and 2 are accepted; in_ready drops to 0 in the cycle after op 2 is accepted; op 3 is held.
  - Release out_ready: outputs arrive in order 1,2,3 with no loss or duplication.
  - flags_q changes only on each retirement.
- DIV a=10 b=0 (any result): div0_pulse for exactly 1 cycle at retirement, flags_q V=1. Then op=001100: illegal_pulse=1, out_wb_en=0, flags_q unchanged.
- Shift flags:
  - SHL a=16'h8001 b=1 gives C=1.
  - SHR a=16'h0002 b=2 gives C=1.
  - ASR a=16'h8000 b=20 gives C=1, result as supplied.
  - SHL b=0 gives C=0.
- Assert rst while both buffer entries are full: out_valid=0 and in_ready=1 immediately (asynchronous); flags_q=0; no pulse fires.

Source files
------------

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------
// | alu_pkg : opcodes, flag bit indices and op classification for the ALU
// | retire stage.  Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_SHL = 6'b000010;
  localparam logic [5:0] OP_SHR = 6'b000011;
  localparam logic [5:0] OP_ASL = 6'b000100;
  localparam logic [5:0] OP_ASR = 6'b000101;
  localparam logic [5:0] OP_MOV = 6'b000110;
  localparam logic [5:0] OP_MUL = 6'b000111;
  localparam logic [5:0] OP_DIV = 6'b001000;
  localparam logic [5:0] OP_MOD = 6'b001001;
  localparam logic [5:0] OP_AND = 6'b001010;
  localparam logic [5:0] OP_OR  = 6'b001011;
  localparam logic [5:0] OP_XOR = 6'b001101;
  localparam logic [5:0] OP_NOT = 6'b001110;
  localparam logic [5:0] OP_CMP = 6'b001111;
  localparam logic [5:0] OP_TST = 6'b010000;
  localparam logic [5:0] OP_INC = 6'b010001;
  localparam logic [5:0] OP_DEC = 6'b010010;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic wb;
    logic fs;
    logic legal;
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    op_class_t cls;
    cls = '{wb: 1'b0, fs: 1'b0, legal: 1'b0};
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC,
      OP_SHL, OP_SHR, OP_ASL, OP_ASR,
      OP_MOV, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_DIV, OP_MOD:  cls = '{wb: 1'b1, fs: 1'b1, legal: 1'b1};
      OP_CMP, OP_TST:  cls = '{wb: 1'b0, fs: 1'b1, legal: 1'b1};
      default:         cls = '{wb: 1'b0, fs: 1'b0, legal: 1'b0};
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// +----------------------------------------------------------------------------
// | alu_flag_gen : combinational Z/N/C/V and divide-by-zero derivation from
// | the ALU operands, opcode and result.  Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [5:0]    op_i,
  input  logic [DW-1:0] result_i,
  output logic [3:0]    flags_o,
  output logic          div0_o
);

  logic       w_b_in_rng;
  logic [3:0] w_lidx;
  logic [3:0] w_ridx;
  logic       w_c;
  logic       w_v;

  always_comb begin
    w_b_in_rng = (b_i != '0) && (b_i <= DW'(16));
    // Modulo-16 arithmetic maps b==16 onto bit 0 (left) and bit 15 (right).
    w_lidx     = 4'd0 - b_i[3:0];
    w_ridx     = b_i[3:0] - 4'd1;
    w_c        = 1'b0;
    w_v        = 1'b0;
    case (op_i)
      OP_ADD: begin
        w_c = a_i > ~b_i;
        w_v = (a_i[DW-1] == b_i[DW-1]) && (result_i[DW-1] != a_i[DW-1]);
      end
      OP_SUB, OP_CMP: begin
        w_c = a_i < b_i;
        w_v = (a_i[DW-1] != b_i[DW-1]) && (result_i[DW-1] != a_i[DW-1]);
      end
      OP_INC: begin
        w_c = &a_i;
        w_v = a_i == {1'b0, {(DW-1){1'b1}}};
      end
      OP_DEC: begin
        w_c = a_i == '0;
        w_v = a_i == {1'b1, {(DW-1){1'b0}}};
      end
      OP_SHL, OP_ASL: w_c = w_b_in_rng & a_i[w_lidx];
      OP_SHR, OP_ASR: begin
        if (w_b_in_rng)
          w_c = a_i[w_ridx];
        else if (op_i == OP_ASR && b_i > DW'(16))
          w_c = a_i[DW-1];
      end
      OP_DIV, OP_MOD: w_v = b_i == '0;
      default: ;
    endcase
    flags_o         = '0;
    flags_o[FLAG_Z] = result_i == '0;
    flags_o[FLAG_N] = result_i[DW-1];
    flags_o[FLAG_C] = w_c;
    flags_o[FLAG_V] = w_v;
    div0_o          = ((op_i == OP_DIV) || (op_i == OP_MOD)) && (b_i == '0);
  end

endmodule

`default_nettype wire

// File: rtl/alu_retire_stage.sv
// +----------------------------------------------------------------------------
// | alu_retire_stage : 2-entry skid buffer behind the ALU with write-back
// | decode and the architectural flag register.  Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_retire_stage
  import alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [5:0]    in_op,
  input  logic [DW-1:0] in_result,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_wb_en,
  output logic [3:0]    flags_q,
  output logic          div0_pulse,
  output logic          illegal_pulse
);

  // Entry layout: {result, rd, wb, fs, legal, div0, flags[3:0]}
  localparam int C_EW   = DW + RW + 8;
  localparam int C_B_WB = 7;
  localparam int C_B_FS = 6;
  localparam int C_B_LG = 5;
  localparam int C_B_D0 = 4;

  logic [3:0]      w_flags;
  logic            w_div0;
  op_class_t       w_cls;
  logic [C_EW-1:0] w_in_entry;
  logic            w_accept;
  logic            w_retire;

  logic            out_valid_q, out_valid_d;
  logic [C_EW-1:0] out_entry_q, out_entry_d;
  logic            skid_valid_q, skid_valid_d;
  logic [C_EW-1:0] skid_entry_q, skid_entry_d;

  alu_flag_gen #(.DW(DW)) u_flag_gen (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_i (in_result),
    .flags_o  (w_flags),
    .div0_o   (w_div0)
  );

  assign w_cls      = op_class(in_op);
  assign w_in_entry = {in_result, in_rd, w_cls.wb, w_cls.fs, w_cls.legal, w_div0, w_flags};
  assign w_accept   = in_valid && in_ready;
  assign w_retire   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_entry_d  = out_entry_q;
    skid_valid_d = skid_valid_q;
    skid_entry_d = skid_entry_q;
    if (!out_valid_q || w_retire) begin
      // The skid entry is older than anything on the input, so it goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_entry_d  = skid_entry_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d  = 1'b1;
        out_entry_d  = w_in_entry;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_entry_d = w_in_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_entry_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_entry_q <= '0;
      flags_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_entry_q  <= out_entry_d;
      skid_valid_q <= skid_valid_d;
      skid_entry_q <= skid_entry_d;
      if (w_retire && out_entry_q[C_B_FS])
        flags_q <= out_entry_q[3:0];
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_entry_q[C_EW-1 -: DW];
  assign out_rd        = out_entry_q[RW+7 -: RW];
  assign out_wb_en     = out_valid_q && out_entry_q[C_B_WB];
  assign div0_pulse    = w_retire && out_entry_q[C_B_D0];
  assign illegal_pulse = w_retire && !out_entry_q[C_B_LG];

endmodule

`default_nettype wire

// File: tb/tb_alu_retire_stage.sv
// +----------------------------------------------------------------------------
// | tb_alu_retire_stage : directed stimulus with a queue-based reference model
// | of the retire stage.  Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_alu_retire_stage;

  localparam logic [5:0] ADD = 6'd0,  SUB = 6'd1,  SHL = 6'd2,  SHR = 6'd3;
  localparam logic [5:0] ASL = 6'd4,  ASR = 6'd5,  MUL = 6'd7,  DIV = 6'd8;
  localparam logic [5:0] MOD = 6'd9,  ANDO = 6'd10, XORO = 6'd13, NOTO = 6'd14;
  localparam logic [5:0] CMP = 6'd15, TST = 6'd16, INC = 6'd17, DEC = 6'd18;
  localparam logic [5:0] BAD = 6'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0, in_result = '0;
  logic [5:0]  in_op = '0;
  logic [2:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wb_en;
  logic [3:0]  flags_q;
  logic        div0_pulse, illegal_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int n_div0  = 0;
  int n_ill   = 0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    bit          wb, fs, ill, d0;
    logic [3:0]  fl;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_flags = '0;

  alu_retire_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .flags_q(flags_q), .div0_pulse(div0_pulse), .illegal_pulse(illegal_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {V,C,N,Z} computed straight from the arithmetic definitions.
  function automatic logic [3:0] ref_flags(input logic [5:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] r);
    int  ai, bi;
    bit  c, v;
    ai = int'(a);
    bi = int'(b);
    c  = 0;
    v  = 0;
    case (op)
      ADD: begin
        c = (ai + bi) > 65535;
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      SUB, CMP: begin
        c = ai < bi;
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      INC: begin c = (ai == 65535); v = (ai == 32767); end
      DEC: begin c = (ai == 0);     v = (ai == 32768); end
      SHL, ASL: if (bi >= 1 && bi <= 16) c = (((ai << bi) >> 16) & 1) != 0;
      SHR, ASR: begin
        if (bi >= 1 && bi <= 16) c = ((ai >> (bi - 1)) & 1) != 0;
        else if (bi > 16 && op == ASR) c = a[15];
      end
      DIV, MOD: v = (bi == 0);
      default: ;
    endcase
    return {v, c, r[15], r == 16'd0};
  endfunction

  function automatic exp_t make_exp(input logic [5:0] op, input logic [15:0] a,
                                    input logic [15:0] b, input logic [15:0] r,
                                    input logic [2:0] rd);
    exp_t e;
    int   o;
    bit   legal;
    o       = int'(op);
    legal   = (o <= 18) && (o != 12);
    e.res   = r;
    e.rd    = rd;
    e.ill   = !legal;
    e.fs    = legal;
    e.wb    = legal && (o != 15) && (o != 16);
    e.d0    = (o == 8 || o == 9) && (b == 16'd0);
    e.fl    = ref_flags(op, a, b, r);
    return e;
  endfunction

  // Compare outputs against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit ret, acc, rdy;
    if (rst) begin
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_flags", {28'd0, flags_q}, 0);
      chk("rst_pulses", {30'd0, div0_pulse, illegal_pulse}, 0);
      chk("rst_out_data", {13'd0, out_result, out_rd, out_wb_en}, 0);
      q.delete();
      m_flags = '0;
    end else begin
      rdy = q.size() < 2;
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
      ret = (q.size() != 0) && out_ready;
      if (q.size() != 0) begin
        chk("out_result", {16'd0, out_result}, {16'd0, q[0].res});
        chk("out_rd", {29'd0, out_rd}, {29'd0, q[0].rd});
        chk("out_wb_en", {31'd0, out_wb_en}, {31'd0, q[0].wb});
      end
      chk("div0_pulse", {31'd0, div0_pulse}, {31'd0, ret && q[0].d0});
      chk("illegal_pulse", {31'd0, illegal_pulse}, {31'd0, ret && q[0].ill});
      if (div0_pulse) n_div0++;
      if (illegal_pulse) n_ill++;
      acc = in_valid && rdy;
      if (ret) begin
        if (q[0].fs) m_flags = q[0].fl;
        void'(q.pop_front());
      end
      if (acc) q.push_back(make_exp(in_op, in_a, in_b, in_result, in_rd));
    end
  end

  task automatic send(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic [2:0] rd);
    bit acc;
    acc       = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_result = r;
    in_rd     = rd;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done      = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #1;
      done = (q.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [11:0] pat;
    ops = '{INC, DEC, MUL, TST, MOD, NOTO};
    pat = 12'b1011_0100_1110;

    chk("model_add", {28'd0, ref_flags(ADD, 16'h7FFF, 16'd1, 16'h8000)}, 32'b1010);
    chk("model_asr", {28'd0, ref_flags(ASR, 16'h8000, 16'd20, 16'hFFFF)}, 32'b0110);
    chk("model_shr", {28'd0, ref_flags(SHR, 16'h0002, 16'd2, 16'h0000)}, 32'b0101);
    chk("model_dec", {28'd0, ref_flags(DEC, 16'h8000, 16'd0, 16'h7FFF)}, 32'b1000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(ADD, 16'h7FFF, 16'd1, 16'h8000, 3'd1);
    drain();
    chk("add_flags", {28'd0, flags_q}, 32'b1010);
    send(SUB, 16'd3, 16'd5, 16'hFFFE, 3'd2);
    drain();
    chk("sub_flags", {28'd0, flags_q}, 32'b0110);
    send(CMP, 16'd9, 16'd9, 16'd0, 3'd3);
    drain();
    chk("cmp_flags", {28'd0, flags_q}, 32'b0001);

    // Backpressure: two fill the buffer, the third waits.
    out_ready = 1'b0;
    send(ANDO, 16'hFFFF, 16'h00FF, 16'h00FF, 3'd4);
    send(XORO, 16'h8001, 16'h0001, 16'h8000, 3'd5);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    fork
      send(ADD, 16'hFFFF, 16'd1, 16'h0000, 3'd6);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_flags_hold", {28'd0, flags_q}, 32'b0001);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_flags", {28'd0, flags_q}, 32'b0101);

    send(DIV, 16'd10, 16'd0, 16'h1234, 3'd7);
    drain();
    chk("div0_flags", {28'd0, flags_q}, 32'b1000);
    chk("div0_once", n_div0, 1);
    send(BAD, 16'd1, 16'd2, 16'd3, 3'd1);
    drain();
    chk("ill_flags", {28'd0, flags_q}, 32'b1000);
    chk("ill_once", n_ill, 1);

    send(SHL, 16'h8001, 16'd1, 16'h0002, 3'd2);
    drain();
    chk("shl_c", {28'd0, flags_q}, 32'b0100);
    send(SHR, 16'h0002, 16'd2, 16'h0000, 3'd3);
    drain();
    chk("shr_c", {28'd0, flags_q}, 32'b0101);
    send(ASR, 16'h8000, 16'd20, 16'hFFFF, 3'd4);
    drain();
    chk("asr_c", {28'd0, flags_q}, 32'b0110);
    send(SHL, 16'hFFFF, 16'd0, 16'hFFFF, 3'd5);
    drain();
    chk("shl0_c", {28'd0, flags_q}, 32'b0010);
    send(ASL, 16'h0001, 16'd16, 16'h0000, 3'd6);
    send(INC, 16'hFFFF, 16'd0, 16'h0000, 3'd7);
    send(DEC, 16'h8000, 16'd0, 16'h7FFF, 3'd0);
    drain();
    chk("dec_flags", {28'd0, flags_q}, 32'b1000);

    // Mixed stream under an irregular out_ready pattern.
    fork
      for (int i = 0; i < 6; i++)
        send(ops[i], 16'(i * 16'h2345), 16'(i), 16'(16'h1111 * i), 3'(i));
      for (int i = 0; i < 12; i++) begin
        out_ready = pat[i];
        @(posedge clk);
        #1;
      end
    join
    drain();

    // Reset with both entries occupied.
    out_ready = 1'b0;
    send(ADD, 16'd1, 16'd2, 16'd3, 3'd1);
    send(SUB, 16'd5, 16'd1, 16'd4, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 0);
    chk("async_in_ready", {31'd0, in_ready}, 1);
    chk("async_flags", {28'd0, flags_q}, 0);
    chk("async_pulses", {30'd0, div0_pulse, illegal_pulse}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_flags", {28'd0, flags_q}, 0);
    send(ADD, 16'h8000, 16'h8000, 16'h0000, 3'd3);
    drain();
    chk("post_rst_add", {28'd0, flags_q}, 32'b1101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
